// File: rtl/mult_seq_control.sv
// Sequencer for a slice-based multiplier: steps one SLICE_W x SLICE_W partial
// product per cycle (A index inner, B index outer) and drives the accumulator.
module mult_seq_control #(
  parameter int SLICE_W = 4,
  parameter int SLICES  = 2,
  localparam int IDX_W  = $clog2(SLICES),
  localparam int SH_W   = $clog2((2*SLICES-2)*SLICE_W+1)
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] a_sel,
  output logic [IDX_W-1:0] b_sel,
  output logic [SH_W-1:0]  shift_amt,
  output logic             clk_ena,
  output logic             sclr_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CLEAR = 3'b001,
    S_CALC  = 3'b010,
    S_DONE  = 3'b011,
    S_ERR   = 3'b100
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES-1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [SH_W-1:0]  SLICE_SH = SH_W'(SLICE_W);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] a_q, a_d;
  logic [IDX_W-1:0] b_q, b_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // NOTE: every variable gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (abort) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_CLEAR;
        S_CLEAR: begin
          a_d = '0;
          b_d = '0;
          state_d = start ? S_ERR : S_CALC;
        end
        S_CALC: begin
          if (start) begin
            state_d = S_ERR;
          end else if (a_q == LAST_IDX && b_q == LAST_IDX) begin
            state_d = S_DONE;
            a_d     = '0;
            b_d     = '0;
          end else if (a_q == LAST_IDX) begin
            a_d = '0;
            b_d = b_q + ONE_IDX;
          end else begin
            a_d = a_q + ONE_IDX;
          end
        end
        S_DONE:  state_d = start ? S_CLEAR : S_IDLE;
        S_ERR:   if (start) state_d = S_CLEAR;
        default: begin
          state_d = S_IDLE;
          a_d     = '0;
          b_d     = '0;
        end
      endcase
    end
  end

  // Moore decode; selects and shift are forced to zero outside CALC
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    shift_amt = '0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    state_out = state_q;
    case (state_q)
      S_CLEAR: begin
        sclr_n = 1'b0;
        busy   = 1'b1;
      end
      S_CALC: begin
        clk_ena   = 1'b1;
        busy      = 1'b1;
        a_sel     = a_q;
        b_sel     = b_q;
        shift_amt = (SH_W'(a_q) + SH_W'(b_q)) * SLICE_SH;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mult_seq_control.md
Name: mult_seq_control

Overview:
- Parametrised sequencer for a slice-based multiplier datapath: an OP_W = SLICES*SLICE_W operand pair is multiplied by one SLICE_W x SLICE_W multiplier, one partial product per cycle, with the results accumulated in a shifting adder.
- Owns its own partial-product counters; no external count input.
- Drives the slice muxes, the shift amount, and the accumulator clock-enable and clear. Reports busy/done/error.
- Sits between the multiplier top-level handshake and the datapath (slice muxes, shifter, accumulator register).

Parameters:
- SLICE_W, 4, width of one operand slice in bits (>=1).
- SLICES, 2, slices per operand (>=2). Partial products P = SLICES*SLICES.
- IDX_W, $clog2(SLICES), width of a_sel/b_sel (derived localparam).
- SH_W, $clog2((2*SLICES-2)*SLICE_W+1), width of shift_amt (derived localparam).

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset_a  in  1  asynchronous active-low reset
- start  in  1  level request; sampled each edge
- abort  in  1  synchronous abort, highest priority after reset
- a_sel  out  IDX_W  slice index of operand A for current partial product
- b_sel  out  IDX_W  slice index of operand B
- shift_amt  out  SH_W  left shift for current product = (a_sel+b_sel)*SLICE_W
- clk_ena  out  1  accumulator load enable
- sclr_n  out  1  accumulator synchronous clear, active low
- busy  out  1  high in CLEAR and CALC
- done  out  1  one-cycle completion pulse
- err  out  1  high while in ERR
- state_out  out  3  current state encoding

Behaviour:
- States and encoding: IDLE=000, CLEAR=001, CALC=010, DONE=011, ERR=100. Other codes return to IDLE on the next edge.
- Registers: state, a_idx, b_idx. All are cleared asynchronously by reset_a=0, giving state IDLE and a_idx = b_idx = 0.
- Output decode: all outputs are Moore, decoded from the registered state and indices. No X is ever driven.
- Reset output values: a_sel=0, b_sel=0, shift_amt=0, clk_ena=0, sclr_n=1, busy=0, done=0, err=0, state_out=000.
- Per-state outputs:
  - IDLE: as reset values.
  - CLEAR: sclr_n=0, busy=1, clk_ena=0.
  - CALC: clk_ena=1, busy=1, a_sel=a_idx, b_sel=b_idx, shift_amt=(a_idx+b_idx)*SLICE_W. Computed at full width; no truncation is possible given SH_W.
  - DONE: done=1.
  - ERR: err=1, clk_ena=0, sclr_n=1.
  - a_sel, b_sel and shift_amt are 0 outside CALC.
- Transitions (abort=1 in any state forces IDLE and clears the indices; it beats start):
  - IDLE: start=1 -> CLEAR; else stay.
  - CLEAR: start=1 -> ERR; else -> CALC with a_idx = b_idx = 0.
  - CALC: start=1 -> ERR, indices frozen.
  - CALC, otherwise: a_idx increments. At a_idx = SLICES-1 it wraps to 0 and b_idx increments.
  - CALC last product (a_idx = b_idx = SLICES-1): -> DONE, indices cleared.
  - DONE: start=1 -> CLEAR (back-to-back run, no IDLE cycle); else -> IDLE.
  - ERR: start=1 -> CLEAR (restart); else stay.
- Start rule: start must be a pulse of exactly one cycle. A start still high one cycle later, or at any point during CLEAR/CALC, is a protocol error.
- Ordering: A index inner, B index outer. Product k has a_idx = k mod SLICES and b_idx = k div SLICES.
- Latency: from the edge sampling start=1 in IDLE:
  - 1 CLEAR cycle, then P CALC cycles, then done high for the single cycle after edge P+1.
  - Back in IDLE after edge P+2.
  - Defaults: P=4, done after edge 5.
- Reset mid-run: returns to IDLE immediately, without waiting for a clock edge.
- Simultaneous abort and start: abort wins and the state goes to IDLE. The start is lost and must be re-issued.

Test Plan:
- Defaults; reset, then a 1-cycle start -> CLEAR (sclr_n=0) for 1 cycle. Then 4 CALC cycles with (a_sel,b_sel,shift_amt) = (0,0,0), (1,0,4), (0,1,4), (1,1,8) and clk_ena=1. Then done=1 for exactly one cycle, then IDLE, with state_out sequence 000,001,010x4,011,000.
- Start held for 2 cycles -> CLEAR then ERR (err=1, state_out=100, clk_ena=0). Stays in ERR with start=0. A 1-cycle start -> CLEAR, then a normal run completes with done=1.
- Abort asserted in the second CALC cycle -> IDLE on the next edge with a_sel=b_sel=0 and no done pulse. The next start gives a full 4-product run starting at (0,0).
- Start=1 during the DONE cycle -> the next state is CLEAR. The second run produces all 4 products and a second done pulse, with no IDLE cycle between runs.
- SLICES=3, SLICE_W=8 -> 9 CALC cycles with shift_amt sequence 0,8,16,8,16,24,16,24,32. The done pulse follows edge 10 after start.
- reset_a driven low asynchronously mid-CALC (between edges) -> outputs immediately take reset values (state_out=000, clk_ena=0). After release, start gives a clean run.
